// File: rtl/sim_pkg.sv
// Shared types, defaults and helpers for the node step scheduler.
package sim_pkg;

    typedef enum logic [2:0] {
        IDLE,
        VERLET,
        CONSTR,
        DONE,
        ERROR
    } sched_state_t;

    localparam int NODE_COUNT_DEFAULT       = 5;
    localparam int CONSTRAINT_ITERS_DEFAULT = 3;
    localparam int TIMEOUT_CYCLES_DEFAULT   = 1024;

    // Widest node array the one-hot helper can address
    localparam int MAX_NODES = 32;

    function automatic logic [MAX_NODES-1:0] onehot(input logic [4:0] idx);
        return {{(MAX_NODES-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Cycle counter guarding one node's enable window; expire flags the last allowed cycle.
module wait_timer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // Restart on every enable rise, then count waiting cycles up to the limit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign expire = enable && (count == LAST);

endmodule

// File: rtl/node_step_scheduler.sv
// Step sequencer for the node array: one Verlet pass over all nodes, then
// CONSTRAINT_ITERS constraint passes, each node handshaked on finish_signal
// with a timeout guard.
module node_step_scheduler
    import sim_pkg::*;
#(
    parameter int NODE_COUNT       = NODE_COUNT_DEFAULT,
    parameter int CONSTRAINT_ITERS = CONSTRAINT_ITERS_DEFAULT,
    parameter int TIMEOUT_CYCLES   = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [NODE_COUNT-1:0]         finish_signal,
    output logic [NODE_COUNT-1:0]         verlet_state,
    output logic [NODE_COUNT-1:0]         fix_constraint_state,
    output logic                          busy,
    output logic                          step_done,
    output logic                          timeout_err,
    output logic [$clog2(NODE_COUNT)-1:0] active_node,
    output logic [31:0]                   step_count
);

    localparam int NW = $clog2(NODE_COUNT);
    localparam logic [NW-1:0] LAST_NODE = NW'(NODE_COUNT - 1);
    localparam logic [3:0]    LAST_ITER = 4'(CONSTRAINT_ITERS - 1);

    sched_state_t          state;
    logic [3:0]            iter;
    logic                  waiting;
    logic                  timer_clear;
    logic                  timer_expire;
    logic [NODE_COUNT-1:0] node_onehot;

    assign node_onehot = NODE_COUNT'(onehot(5'(active_node)));

    // Each node visit opens with one all-low gap cycle (waiting=0); the enable
    // rises on the following edge, which is also where the timer restarts.
    assign timer_clear = ((state == VERLET) || (state == CONSTR)) && !waiting;

    wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (waiting),
        .expire (timer_expire)
    );

    // Sequencer FSM with registered enables, status flags and step counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                <= IDLE;
            active_node          <= '0;
            iter                 <= '0;
            waiting              <= 1'b0;
            verlet_state         <= '0;
            fix_constraint_state <= '0;
            busy                 <= 1'b0;
            step_done            <= 1'b0;
            timeout_err          <= 1'b0;
            step_count           <= '0;
        end else begin
            step_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= VERLET;
                        active_node <= '0;
                        iter        <= '0;
                        waiting     <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                VERLET, CONSTR: begin
                    if (!waiting) begin
                        waiting <= 1'b1;
                        if (state == VERLET) begin
                            verlet_state <= node_onehot;
                        end else begin
                            fix_constraint_state <= node_onehot;
                        end
                    end else if (finish_signal[active_node]) begin
                        // finish wins over a simultaneous timeout expiry
                        waiting              <= 1'b0;
                        verlet_state         <= '0;
                        fix_constraint_state <= '0;
                        if (active_node != LAST_NODE) begin
                            active_node <= active_node + 1'b1;
                        end else begin
                            active_node <= '0;
                            if (state == VERLET) begin
                                state <= CONSTR;
                                iter  <= '0;
                            end else if (iter != LAST_ITER) begin
                                iter <= iter + 1'b1;
                            end else begin
                                state      <= DONE;
                                step_done  <= 1'b1;
                                step_count <= step_count + 32'd1;
                            end
                        end
                    end else if (timer_expire) begin
                        waiting              <= 1'b0;
                        verlet_state         <= '0;
                        fix_constraint_state <= '0;
                        busy                 <= 1'b0;
                        timeout_err          <= 1'b1;
                        state                <= ERROR;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                ERROR: begin
                    state <= ERROR;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
